// File: rtl/ptp_tsu_pkg.sv
// Shared constants, entry layout and helpers for the PTP timestamp unit.
package ptp_tsu_pkg;

    localparam int unsigned TS_W    = 64;
    localparam int unsigned INFOR_W = 20;
    localparam int unsigned ENTRY_W = INFOR_W + TS_W;

    typedef struct packed {
        logic [3:0]  msgid;
        logic [15:0] seqid;
        logic [31:0] sec;
        logic [31:0] ns;
    } ts_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ptp_ts_fifo.sv
// Generic synchronous FIFO: separate occupancy counter, registered read port, flush.
module ptp_ts_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 84,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             push_acc,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             pop_acc;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FullLvl);
    assign level    = level_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Flush wins over both ports; a pop frees a slot for a push in the same cycle.
    always_comb begin
        pop_acc    = pop && !empty && !flush;
        push_acc   = push && (!full || pop_acc) && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_acc) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (push_acc && !pop_acc) level_d = level_q + LW'(1);
            if (!push_acc && pop_acc) level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ptp_ts_queue.sv
// Timestamp queue: captures RTC at SOP, queues {infor, ts} on each parser event rise.
module ptp_ts_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = ptp_tsu_pkg::TS_W,
    parameter int unsigned INFOR_W = ptp_tsu_pkg::INFOR_W,
    localparam int unsigned LW = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    int_valid,
    input  logic                    int_sop,
    input  logic [TS_W-1:0]         rtc_time,
    input  logic                    ptp_found,
    input  logic [INFOR_W-1:0]      ptp_infor,
    input  logic                    q_rd_en,
    input  logic                    q_flush,
    output logic [INFOR_W+TS_W-1:0] q_rd_data,
    output logic                    q_rd_valid,
    output logic                    q_empty,
    output logic                    q_full,
    output logic [LW-1:0]           q_level,
    output logic                    q_overflow,
    output logic [7:0]              q_drop_cnt
);

    logic [TS_W-1:0] sop_ts_q, sop_ts_d;
    logic            found_d1_q;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            push_req, push_acc, drop;

    assign push_req = ptp_found && !found_d1_q;

    always_comb begin
        sop_ts_d   = (int_valid && int_sop) ? rtc_time : sop_ts_q;
        // A flushed push is discarded silently, not counted as a drop.
        drop       = push_req && !push_acc && !q_flush;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop ? ptp_tsu_pkg::sat_inc8(drop_cnt_q) : drop_cnt_q;
        if (q_flush) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sop_ts_q   <= '0;
            found_d1_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sop_ts_q   <= sop_ts_d;
            found_d1_q <= ptp_found;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign q_overflow = overflow_q;
    assign q_drop_cnt = drop_cnt_q;

    // Push uses the pre-update sop_ts so a coincident SOP does not leak into the entry.
    ptp_ts_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INFOR_W + TS_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data ({ptp_infor, sop_ts_q}),
        .pop       (q_rd_en),
        .flush     (q_flush),
        .push_acc  (push_acc),
        .rd_data   (q_rd_data),
        .rd_valid  (q_rd_valid),
        .empty     (q_empty),
        .full      (q_full),
        .level     (q_level)
    );

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Self-checking bench for ptp_ts_queue: packet table, scoreboard of popped entries, corner sequences.
module tb_ptp_ts_queue;
    import ptp_tsu_pkg::*;

    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          int_valid, int_sop, ptp_found, q_rd_en, q_flush;
    logic [63:0]   rtc_time;
    logic [19:0]   ptp_infor;
    logic [83:0]   q_rd_data;
    logic          q_rd_valid, q_empty, q_full, q_overflow;
    logic [4:0]    q_level;
    logic [7:0]    q_drop_cnt;

    int total = 0;
    int bad = 0;
    int m_level = 0;
    logic [83:0] sb[$];

    ptp_ts_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .int_valid  (int_valid),
        .int_sop    (int_sop),
        .rtc_time   (rtc_time),
        .ptp_found  (ptp_found),
        .ptp_infor  (ptp_infor),
        .q_rd_en    (q_rd_en),
        .q_flush    (q_flush),
        .q_rd_data  (q_rd_data),
        .q_rd_valid (q_rd_valid),
        .q_empty    (q_empty),
        .q_full     (q_full),
        .q_level    (q_level),
        .q_overflow (q_overflow),
        .q_drop_cnt (q_drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && q_rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected act=%h exp=none", q_rd_data);
            end else begin
                chk("rd_data", q_rd_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [83:0] e);
        if (m_level < DEPTH) begin
            sb.push_back(e);
            m_level++;
        end
    endtask

    task automatic pkt_sop(input logic [63:0] ts);
        int_valid = 1'b1;
        int_sop   = 1'b1;
        rtc_time  = ts;
        ptp_found = 1'b0;
        tick();
        int_sop  = 1'b0;
        rtc_time = ts + 64'd7;
    endtask

    task automatic send_pkt(input logic [63:0] ts, input logic [19:0] inf, input bit ev,
                            input int nwords);
        pkt_sop(ts);
        for (int w = 1; w < nwords; w++) begin
            if (ev && w == 1) begin
                ptp_found = 1'b1;
                ptp_infor = inf;
                model_push({inf, ts});
            end
            tick();
        end
        int_valid = 1'b0;
    endtask

    task automatic rd_one();
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        if (m_level > 0) m_level--;
    endtask

    typedef struct {
        logic [63:0] ts;
        logic [19:0] inf;
        bit          ev;
        int          nw;
        int          lvl;
    } vec_t;

    vec_t vecs[7];
    ts_entry_t got;

    initial begin
        vecs[0] = '{64'h0000_0020_0000_0100, 20'h1_0001, 1'b0, 12, 0};
        vecs[1] = '{64'h0000_0020_0000_0200, 20'h1_0002, 1'b0, 5,  0};
        vecs[2] = '{64'h0000_0020_0000_0300, 20'h1_0003, 1'b0, 15, 0};
        vecs[3] = '{64'h0000_0020_0000_0400, 20'h2_0004, 1'b1, 25, 1};
        vecs[4] = '{64'h0000_0020_0000_0500, 20'h3_0005, 1'b1, 12, 2};
        vecs[5] = '{64'h0000_0020_0000_0600, 20'h4_0006, 1'b0, 8,  2};
        vecs[6] = '{64'h0000_0020_0000_0700, 20'h5_0007, 1'b1, 10, 3};

        rst_n = 1'b0; int_valid = 0; int_sop = 0; ptp_found = 0; q_rd_en = 0; q_flush = 0;
        rtc_time = 64'h0; ptp_infor = 20'h0;
        tick(); tick();
        chk("rst_empty", 84'(q_empty), 84'(1));
        chk("rst_full", 84'(q_full), 84'(0));
        chk("rst_level", 84'(q_level), 84'(0));
        chk("rst_valid", 84'(q_rd_valid), 84'(0));
        chk("rst_data", q_rd_data, 84'(0));
        chk("rst_ovf_drop", {75'(0), q_overflow, q_drop_cnt}, 84'(0));
        rst_n = 1'b1;
        tick();

        // Single Sync packet
        send_pkt(64'h0000_0010_1234_5678, 20'h0_00A5, 1'b1, 12);
        chk("sync_level", 84'(q_level), 84'(1));
        rd_one();
        got = q_rd_data;
        chk("sync_valid", 84'(q_rd_valid), 84'(1));
        chk("sync_seqid", 84'(got.seqid), 84'(16'h00A5));
        chk("sync_ts", 84'({got.sec, got.ns}), 84'(64'h0000_0010_1234_5678));
        chk("sync_empty", 84'(q_empty), 84'(1));

        // Packet table: non-event, short and long-held found packets
        foreach (vecs[i]) begin
            send_pkt(vecs[i].ts, vecs[i].inf, vecs[i].ev, vecs[i].nw);
            chk($sformatf("vec%0d_level", i), 84'(q_level), 84'(vecs[i].lvl));
        end
        repeat (3) rd_one();
        tick();
        chk("vec_drained", 84'(q_empty), 84'(1));

        // Back-to-back: found rises together with next SOP
        pkt_sop(64'h0000_0030_0000_1111);
        repeat (3) tick();
        int_sop = 1'b1; rtc_time = 64'h0000_0030_0000_2222;
        ptp_found = 1'b1; ptp_infor = 20'h6_0B01;
        model_push({20'h6_0B01, 64'h0000_0030_0000_1111});
        tick();
        int_sop = 1'b0; ptp_found = 1'b0;
        tick(); tick();
        ptp_found = 1'b1; ptp_infor = 20'h6_0B02;
        model_push({20'h6_0B02, 64'h0000_0030_0000_2222});
        tick();
        int_valid = 1'b0;
        chk("b2b_level", 84'(q_level), 84'(2));
        rd_one(); rd_one();
        tick();

        // Overflow: 18 events with no reads
        for (int i = 0; i < 18; i++)
            send_pkt(64'h0000_0040_0000_0000 + 64'(i), 20'h1_0000 + 20'(i), 1'b1, 3);
        chk("ovf_full", 84'(q_full), 84'(1));
        chk("ovf_level", 84'(q_level), 84'(16));
        chk("ovf_sticky", 84'(q_overflow), 84'(1));
        chk("ovf_drop2", 84'(q_drop_cnt), 84'(2));
        pkt_sop(64'h0000_0041_0000_0000);
        ptp_found = 1'b1; ptp_infor = 20'h7_0777; q_rd_en = 1'b1;
        sb.push_back({20'h7_0777, 64'h0000_0041_0000_0000});
        tick();
        q_rd_en = 1'b0; int_valid = 1'b0;
        chk("full_rdpush_level", 84'(q_level), 84'(16));
        chk("full_rdpush_drop", 84'(q_drop_cnt), 84'(2));
        for (int i = 0; i < 260; i++)
            send_pkt(64'h0000_0050_0000_0000 + 64'(i), 20'h2_0000 + 20'(i), 1'b1, 3);
        chk("drop_sat", 84'(q_drop_cnt), 84'(255));

        // Flush from full, coincident with a push
        pkt_sop(64'h0000_0060_0000_0000);
        ptp_found = 1'b1; q_flush = 1'b1;
        tick();
        q_flush = 1'b0; int_valid = 1'b0;
        sb.delete(); m_level = 0;
        chk("flush_full_level", 84'(q_level), 84'(0));
        chk("flush_full_drop", 84'(q_drop_cnt), 84'(0));
        chk("flush_full_ovf", 84'(q_overflow), 84'(0));

        // Flush with 5 entries queued plus a coincident push
        for (int i = 0; i < 5; i++)
            send_pkt(64'h0000_0070_0000_0000 + 64'(i), 20'h3_0000 + 20'(i), 1'b1, 3);
        chk("pre_flush_level", 84'(q_level), 84'(5));
        pkt_sop(64'h0000_0071_0000_0000);
        ptp_found = 1'b1; q_flush = 1'b1;
        tick();
        q_flush = 1'b0; int_valid = 1'b0;
        sb.delete(); m_level = 0;
        chk("flush5_level", 84'(q_level), 84'(0));
        chk("flush5_drop", 84'(q_drop_cnt), 84'(0));
        chk("flush5_empty", 84'(q_empty), 84'(1));
        q_rd_en = 1'b1; ptp_found = 1'b0;
        tick();
        q_rd_en = 1'b0;
        chk("empty_rd_nopulse", 84'(q_rd_valid), 84'(0));
        chk("empty_rd_level", 84'(q_level), 84'(0));

        // Reset mid-read
        send_pkt(64'h0000_0080_0000_0001, 20'h4_0001, 1'b1, 3);
        send_pkt(64'h0000_0080_0000_0002, 20'h4_0002, 1'b1, 3);
        q_rd_en = 1'b1;
        tick();
        chk("pre_rst_valid", 84'(q_rd_valid), 84'(1));
        #1 rst_n = 1'b0;
        sb.delete(); m_level = 0;
        #1;
        chk("rst_mid_valid", 84'(q_rd_valid), 84'(0));
        chk("rst_mid_empty", 84'(q_empty), 84'(1));
        chk("rst_mid_level", 84'(q_level), 84'(0));
        q_rd_en = 1'b0; ptp_found = 1'b0;
        #1 rst_n = 1'b1;
        tick();

        // Ordering across the pointer wrap
        for (int i = 0; i < 5; i++)
            send_pkt(64'h0000_0090_0000_0000 + 64'(i), 20'h5_0000 + 20'(i), 1'b1, 3);
        repeat (5) rd_one();
        for (int i = 0; i < 16; i++)
            send_pkt(64'h0000_00A0_0000_0000 + 64'(i), 20'h8_0100 + 20'(i), 1'b1, 3);
        chk("wrap_full", 84'(q_full), 84'(1));
        repeat (16) rd_one();
        tick();
        chk("wrap_empty", 84'(q_empty), 84'(1));
        tick();
        chk("sb_drained", 84'(sb.size()), 84'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptp_ts_queue.md
Name: ptp_ts_queue

Overview:
- Downstream consumer of ptp_parser on the TSU path.
- Snapshots RTC time at every start-of-packet on the parser's input stream.
- When the parser flags a PTP event message, pushes {ptp_infor, SOP timestamp} into a synchronous FIFO.
- The host register interface drains the FIFO by single-word reads.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- TS_W, 64, timestamp width, {sec[31:0], ns[31:0]}.
- INFOR_W, 20, parser info width, {msgid[3:0], seqid[15:0]}.

Ports:
- clk  in  1  single clock; the parser stream and the register read side share it.
- rst_n  in  1  asynchronous active-low reset.
- int_valid  in  1  stream word valid, same signal that feeds ptp_parser.
- int_sop  in  1  stream start-of-packet, qualified by int_valid.
- rtc_time  in  TS_W  current RTC time, sampled at SOP.
- ptp_found  in  1  parser output: event message found, level held until the next SOP.
- ptp_infor  in  INFOR_W  parser output: {msgid, seqid}.
- q_rd_en  in  1  pop request from the register block.
- q_flush  in  1  synchronous clear of the queue.
- q_rd_data  out  INFOR_W+TS_W  popped entry, {infor, sec, ns}.
- q_rd_valid  out  1  q_rd_data valid pulse.
- q_empty  out  1  FIFO empty.
- q_full  out  1  FIFO full.
- q_level  out  clog2(DEPTH)+1  occupancy, 0..DEPTH.
- q_overflow  out  1  sticky: at least one entry was dropped because the FIFO was full.
- q_drop_cnt  out  8  dropped-entry count, saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pointers, q_level and q_drop_cnt = 0; q_overflow = 0; q_rd_valid = 0; q_rd_data = 0.
  - q_empty = 1, q_full = 0.
  - sop_ts = 0; found_d1 = 0.
  - Reset mid-operation discards all entries and any in-flight read.
- SOP capture: on int_valid && int_sop, sop_ts <= rtc_time. sop_ts holds until the next qualified SOP.
- Event detection: push_req = ptp_found && !found_d1, with found_d1 <= ptp_found every cycle.
  - Exactly one push per packet, since ptp_found rises at most once per packet.
  - A non-event PTP packet or a truncated packet (fewer than 10 words) gives no rise and no push.
- Push data = {ptp_infor, sop_ts}, using the pre-update value of sop_ts.
  - If push_req and a new qualified SOP occur in the same cycle, the entry carries the previous packet's timestamp.
  - This case arises when the parser's found word is the last word and a back-to-back SOP follows.
- Push accept: push_req && (!q_full || pop_acc).
  - Push while full with no pop: entry is dropped, q_overflow <= 1, q_drop_cnt increments with saturation at 255.
- Pop accept: pop_acc = q_rd_en && !q_empty.
  - On pop_acc, q_rd_data <= head entry and q_rd_valid = 1 in the next cycle (1-cycle latency).
  - q_rd_data holds its value until the next pop.
  - q_rd_en while empty is ignored: no pulse, no state change. There is no empty-bypass, so push and rd_en in the same cycle while empty pops nothing.
- Simultaneous push_acc and pop_acc: q_level is unchanged and both pointers advance. This is legal when full, in which case nothing is dropped.
- Pointers: clog2(DEPTH)-bit, wrap modulo DEPTH. q_level is tracked separately; q_full = (q_level == DEPTH), q_empty = (q_level == 0).
- Flush (q_flush = 1):
  - next cycle: q_level = 0, pointers = 0, q_overflow = 0, q_drop_cnt = 0, q_rd_valid = 0.
  - Flush has priority over push and pop in the same cycle; the push is neither stored nor counted as a drop.
  - sop_ts and found_d1 are unaffected.
- All outputs are registered except q_empty, q_full and q_level, which are registered-state derived.

Decomposition:
- Shared package ptp_tsu_pkg:
  - constants TS_W = 64, INFOR_W = 20, ENTRY_W = 84.
  - struct ts_entry_t {msgid[3:0], seqid[15:0], sec[31:0], ns[31:0]}.
- One sub-module, ptp_ts_fifo: generic synchronous FIFO with DEPTH and WIDTH parameters, push/pop/flush, level, full/empty and registered read.
- The top level holds SOP capture, edge detection and drop accounting.

Test Plan:
- Single Sync packet: SOP while rtc_time = 0x0000_0010_1234_5678, parser raises ptp_found with infor = 0x0_00A5 -> q_level = 1; q_rd_en -> next cycle q_rd_valid = 1, q_rd_data = {0x0_00A5, 0x0000_0010_1234_5678}, q_empty = 1.
- Non-event and short packets: ptp_found stays 0 for 3 packets -> q_level = 0, no q_rd_valid pulse; ptp_found held high for 20 cycles -> exactly one push.
- Back-to-back: found rises in the same cycle as the next SOP with rtc_time = T2 -> entry carries T1; a second event in the next packet carries T2.
- Overflow, DEPTH = 16: 18 events, no reads -> q_full = 1, q_level = 16, q_overflow = 1, q_drop_cnt = 2; push with q_rd_en while full -> accepted, q_level stays 16, drop_cnt stays 2; 260 drops -> q_drop_cnt = 255.
- Flush and reset: q_flush in the same cycle as a push with 5 entries queued -> q_level = 0, q_drop_cnt = 0, q_overflow = 0; rst_n pulled low mid-read -> q_rd_valid = 0 immediately, q_empty = 1.
- Empty read and ordering: q_rd_en on an empty FIFO -> no pulse; 16 pushes then 16 pops -> seqids come out in FIFO order across the pointer wrap.
